// File: rtl/sgd_pkg.sv
// Shared SGD engine constants and the x-load state encoding.
package sgd_pkg;
   localparam int ENGINE_NUM        = 8;
   localparam int NUM_BITS_PER_BANK = 64;
   localparam int X_WORD_BITS       = NUM_BITS_PER_BANK * 32;
   localparam int DIS_X_BIT_DEPTH   = 10;
   localparam int BEAT_BITS         = 512;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_CMD,
      ST_DATA,
      ST_DONE
   } ld_state_e;
endpackage

// File: rtl/sgd_x_beat_packer.sv
// Packs four 512-bit response beats into one bank word; word and word_vld
// are registered, so a word appears the cycle after its fourth beat.
module sgd_x_beat_packer (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            beat_vld,
   input  logic [sgd_pkg::BEAT_BITS-1:0]   beat_dat,
   output logic                            last_slot,
   output logic                            word_vld,
   output logic [sgd_pkg::X_WORD_BITS-1:0] word_dat
);
   import sgd_pkg::*;

   logic [1:0]               slot_q, slot_d;
   logic [3*BEAT_BITS-1:0]   buf_q, buf_d;
   logic [X_WORD_BITS-1:0]   word_q, word_d;
   logic                     word_vld_q, word_vld_d;

   always_comb begin
      slot_d     = slot_q;
      buf_d      = buf_q;
      word_d     = word_q;
      word_vld_d = 1'b0;
      last_slot  = beat_vld && (slot_q == 2'd3);
      if (beat_vld) begin
         slot_d = slot_q + 2'd1;
         case (slot_q)
            2'd0:    buf_d[BEAT_BITS-1:0]             = beat_dat;
            2'd1:    buf_d[2*BEAT_BITS-1:BEAT_BITS]   = beat_dat;
            2'd2:    buf_d[3*BEAT_BITS-1:2*BEAT_BITS] = beat_dat;
            default: begin
               // slot 3 goes straight to the output word, never through buf
               word_d     = {beat_dat, buf_q};
               word_vld_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_q     <= '0;
         buf_q      <= '0;
         word_q     <= '0;
         word_vld_q <= 1'b0;
      end else begin
         slot_q     <= slot_d;
         buf_q      <= buf_d;
         word_q     <= word_d;
         word_vld_q <= word_vld_d;
      end
   end

   assign word_vld = word_vld_q;
   assign word_dat = word_q;
endmodule

// File: rtl/sgd_rd_x_from_memory.sv
// Loads model vector x from host memory: one DMA read for whole rows, then
// each group of four beats becomes one bank word written round-robin across engines.
module sgd_rd_x_from_memory #(
   parameter int ENGINE_NUM        = sgd_pkg::ENGINE_NUM,
   parameter int NUM_BITS_PER_BANK = sgd_pkg::NUM_BITS_PER_BANK,
   parameter int X_DEPTH_BITS      = sgd_pkg::DIS_X_BIT_DEPTH
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              load_x_en,
   input  logic [63:0]                       addr_model,
   input  logic [31:0]                       dimension,
   output logic                              load_x_done,
   output logic                              load_x_error,
   output logic                              x_rd_cmd_valid,
   input  logic                              x_rd_cmd_ready,
   output logic [63:0]                       x_rd_cmd_addr,
   output logic [31:0]                       x_rd_cmd_length,
   input  logic [511:0]                      x_data_in,
   input  logic                              x_data_in_valid,
   output logic                              x_data_in_ready,
   output logic [X_DEPTH_BITS-1:0]           x_mem_wr_addr,
   output logic [ENGINE_NUM-1:0]             x_mem_wr_en,
   output logic [NUM_BITS_PER_BANK*32-1:0]   x_mem_wr_data,
   output logic [31:0]                       x_beat_cnt
);
   import sgd_pkg::*;

   localparam int ROW_FEAT      = ENGINE_NUM * NUM_BITS_PER_BANK;
   localparam int ROW_SHIFT     = $clog2(ROW_FEAT);
   localparam int BEATS_PER_ROW = ENGINE_NUM * 4;
   localparam int ROW_BYTES     = BEATS_PER_ROW * 64;
   localparam int EW            = $clog2(ENGINE_NUM);

   ld_state_e             state_q, state_d;
   logic [63:0]           addr_q, addr_d;
   logic [31:0]           dim_q, dim_d;
   logic [32:0]           rows_q, rows_d;
   logic [31:0]           len_q, len_d;
   logic [EW-1:0]         eng_q, eng_d;
   logic [32:0]           row_q, row_d;
   logic                  cmd_vld_q, cmd_vld_d;
   logic                  rdy_q, rdy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [ENGINE_NUM-1:0] wr_en_q, wr_en_d;
   logic [X_DEPTH_BITS-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]           beat_cnt_q, beat_cnt_d;

   logic                  beat_acc;
   logic                  last_slot;
   logic                  word_vld;
   logic [32:0]           rows_calc;
   logic [31:0]           len_calc;

   assign beat_acc  = x_data_in_valid && rdy_q;
   assign rows_calc = ({1'b0, dim_q} + 33'(ROW_FEAT - 1)) >> ROW_SHIFT;
   assign len_calc  = 32'(rows_calc * 33'(ROW_BYTES));

   sgd_x_beat_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .beat_vld  (beat_acc),
      .beat_dat  (x_data_in),
      .last_slot (last_slot),
      .word_vld  (word_vld),
      .word_dat  (x_mem_wr_data)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      dim_d      = dim_q;
      rows_d     = rows_q;
      len_d      = len_q;
      eng_d      = eng_q;
      row_d      = row_q;
      cmd_vld_d  = cmd_vld_q;
      rdy_d      = rdy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      wr_en_d    = '0;
      wr_addr_d  = wr_addr_q;
      beat_cnt_d = beat_acc ? beat_cnt_q + 32'd1 : beat_cnt_q;
      case (state_q)
         ST_IDLE: if (load_x_en) begin
            err_d   = 1'b0;
            addr_d  = addr_model;
            dim_d   = dimension;
            state_d = ST_CALC;
         end
         ST_CALC: begin
            rows_d = rows_calc;
            len_d  = len_calc;
            eng_d  = '0;
            row_d  = '0;
            if (dim_q == 32'd0) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               cmd_vld_d = 1'b1;
               state_d   = ST_CMD;
            end
         end
         ST_CMD: if (x_rd_cmd_ready) begin
            cmd_vld_d = 1'b0;
            rdy_d     = 1'b1;
            state_d   = ST_DATA;
         end
         ST_DATA: if (beat_acc && last_slot) begin
            wr_en_d   = {{(ENGINE_NUM-1){1'b0}}, 1'b1} << eng_q;
            wr_addr_d = row_q[X_DEPTH_BITS-1:0];
            if (eng_q == EW'(ENGINE_NUM - 1)) begin
               eng_d = '0;
               row_d = row_q + 33'd1;
               // final write and done land in the same cycle
               if (row_q == rows_q - 33'd1) begin
                  rdy_d   = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end
            end else begin
               eng_d = eng_q + EW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         dim_q      <= '0;
         rows_q     <= '0;
         len_q      <= '0;
         eng_q      <= '0;
         row_q      <= '0;
         cmd_vld_q  <= 1'b0;
         rdy_q      <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         wr_en_q    <= '0;
         wr_addr_q  <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         dim_q      <= dim_d;
         rows_q     <= rows_d;
         len_q      <= len_d;
         eng_q      <= eng_d;
         row_q      <= row_d;
         cmd_vld_q  <= cmd_vld_d;
         rdy_q      <= rdy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign x_rd_cmd_valid  = cmd_vld_q;
   assign x_rd_cmd_addr   = addr_q;
   assign x_rd_cmd_length = len_q;
   assign x_data_in_ready = rdy_q;
   assign x_mem_wr_en     = word_vld ? wr_en_q : '0;
   assign x_mem_wr_addr   = wr_addr_q;
   assign load_x_done     = done_q;
   assign load_x_error    = err_q;
   assign x_beat_cnt      = beat_cnt_q;
endmodule

// File: tb/tb_sgd_rd_x_from_memory.sv
// Randomized loads of x checked through scoreboard queues of expected
// commands, bank writes and done events.
module tb_sgd_rd_x_from_memory;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_x_en = 1'b0;
   logic [63:0]   addr_model = '0;
   logic [31:0]   dimension = '0;
   logic          load_x_done, load_x_error;
   logic          x_rd_cmd_valid;
   logic          x_rd_cmd_ready = 1'b0;
   logic [63:0]   x_rd_cmd_addr;
   logic [31:0]   x_rd_cmd_length;
   logic [511:0]  x_data_in = '0;
   logic          x_data_in_valid = 1'b0;
   logic          x_data_in_ready;
   logic [9:0]    x_mem_wr_addr;
   logic [7:0]    x_mem_wr_en;
   logic [2047:0] x_mem_wr_data;
   logic [31:0]   x_beat_cnt;

   always #5 clk = ~clk;

   sgd_rd_x_from_memory #(.ENGINE_NUM(8), .NUM_BITS_PER_BANK(64), .X_DEPTH_BITS(10)) dut (
      .clk(clk), .rst_n(rst_n), .load_x_en(load_x_en), .addr_model(addr_model),
      .dimension(dimension), .load_x_done(load_x_done), .load_x_error(load_x_error),
      .x_rd_cmd_valid(x_rd_cmd_valid), .x_rd_cmd_ready(x_rd_cmd_ready),
      .x_rd_cmd_addr(x_rd_cmd_addr), .x_rd_cmd_length(x_rd_cmd_length),
      .x_data_in(x_data_in), .x_data_in_valid(x_data_in_valid),
      .x_data_in_ready(x_data_in_ready), .x_mem_wr_addr(x_mem_wr_addr),
      .x_mem_wr_en(x_mem_wr_en), .x_mem_wr_data(x_mem_wr_data), .x_beat_cnt(x_beat_cnt)
   );

   typedef struct { logic [63:0] addr; logic [31:0] len; } cmd_t;
   typedef struct { logic [7:0] en; logic [9:0] addr; logic [2047:0] data; } wr_t;

   cmd_t exp_cmd[$];
   wr_t  exp_wr[$];
   bit   exp_done[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   exp_beats = 0;
   wr_t  w_m;
   bit   e_m;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] rnd_beat();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Scoreboard monitor: consumes expected events whenever the DUT presents them.
   always @(negedge clk) begin
      if (rst_n) begin
         if (x_rd_cmd_valid) begin
            if (exp_cmd.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_cmd: addr %0h len %0d, none expected", x_rd_cmd_addr, x_rd_cmd_length);
            end else begin
               check("cmd_addr", x_rd_cmd_addr, exp_cmd[0].addr);
               check("cmd_length", 64'(x_rd_cmd_length), 64'(exp_cmd[0].len));
            end
         end
         if (x_mem_wr_en != 8'd0) begin
            if (exp_wr.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_write: en %0h addr %0d, none expected", x_mem_wr_en, x_mem_wr_addr);
            end else begin
               w_m = exp_wr.pop_front();
               check("wr_en", 64'(x_mem_wr_en), 64'(w_m.en));
               check("wr_addr", 64'(x_mem_wr_addr), 64'(w_m.addr));
               vectors++;
               if (x_mem_wr_data !== w_m.data) begin
                  miscompares++;
                  $display("FAIL wr_data: got low word %h, expected low word %h", x_mem_wr_data[63:0], w_m.data[63:0]);
               end
            end
         end
         if (load_x_done) begin
            if (exp_done.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_done: got 1, expected 0");
            end else begin
               e_m = exp_done.pop_front();
               check("done_error", 64'(load_x_error), 64'(e_m));
               if (!e_m) begin
                  check("final_write_with_done", 64'(x_mem_wr_en != 8'd0), 64'd1);
                  check("writes_left_at_done", 64'(exp_wr.size()), 64'd0);
               end
            end
         end
      end
   end

   task automatic apply_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; load_x_en = 1'b0; x_data_in_valid = 1'b0; x_rd_cmd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_beats = 0;
   endtask

   task automatic run_load(input logic [31:0] dim, input logic [63:0] addr, input int cmd_delay,
                           input int gap_pct, input int abort_after, input bit restart);
      longint       rows;
      int           nbeats, limit, idx, cyc;
      logic [511:0] beats[$];
      bit           rdy_s, cv_s, hs;
      rows   = (longint'(dim) + 511) / 512;
      nbeats = int'(rows) * 32;
      limit  = (abort_after >= 0 && abort_after < nbeats) ? abort_after : nbeats;
      for (int i = 0; i < nbeats; i++) beats.push_back(rnd_beat());
      if (dim != 0) exp_cmd.push_back('{addr, 32'(rows * 2048)});
      for (int w = 0; w < limit / 4; w++) begin
         wr_t x;
         x.en   = 8'(1 << (w % 8));
         x.addr = 10'(w / 8);
         x.data = {beats[4*w+3], beats[4*w+2], beats[4*w+1], beats[4*w]};
         exp_wr.push_back(x);
      end
      if (limit == nbeats) exp_done.push_back(dim == 0);

      @(posedge clk); #1;
      load_x_en = 1'b1; addr_model = addr; dimension = dim;
      x_data_in_valid = (limit > 0);
      x_data_in = (nbeats > 0) ? beats[0] : '0;
      x_rd_cmd_ready = 1'b0;
      @(posedge clk); #1 load_x_en = 1'b0;
      @(negedge clk);
      check("cmd_vld_in_calc", 64'(x_rd_cmd_valid), 64'd0);
      @(negedge clk);
      if (dim == 0) begin
         check("zero_dim_done", 64'(load_x_done), 64'd1);
         check("zero_dim_error", 64'(load_x_error), 64'd1);
         check("zero_dim_no_cmd", 64'(x_rd_cmd_valid), 64'd0);
         x_data_in_valid = 1'b0;
         repeat (3) @(posedge clk);
         return;
      end
      check("cmd_vld_latency", 64'(x_rd_cmd_valid), 64'd1);

      idx = 0; cyc = 0; hs = 1'b0;
      while (idx < limit && cyc < 5000) begin
         rdy_s = x_data_in_ready;
         cv_s  = x_rd_cmd_valid;
         @(posedge clk);
         if (x_data_in_valid && rdy_s) idx++;
         if (cv_s && x_rd_cmd_ready && !hs) begin
            hs = 1'b1;
            void'(exp_cmd.pop_front());
         end
         cyc++;
         #1;
         x_rd_cmd_ready  = (cyc > cmd_delay);
         x_data_in_valid = (idx < limit) && ($urandom_range(99) >= gap_pct);
         x_data_in       = (idx < nbeats) ? beats[idx] : '0;
         load_x_en       = restart && idx >= 5 && idx < 8;
         @(negedge clk);
      end
      x_data_in_valid = 1'b0;
      load_x_en = 1'b0;
      if (cyc >= 5000) begin
         vectors++; miscompares++;
         $display("FAIL load_timeout: %0d beats accepted, expected %0d", idx, limit);
      end
      if (limit < nbeats) begin
         repeat (2) @(posedge clk);
         apply_reset();
      end else begin
         cyc = 0;
         while (exp_done.size() != 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
         end
         check("done_seen", 64'(exp_done.size()), 64'd0);
         exp_beats += nbeats;
         @(negedge clk);
         check("beat_cnt", 64'(x_beat_cnt), 64'(exp_beats));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_valid", 64'(x_rd_cmd_valid), 64'd0);
      check("rst_data_ready", 64'(x_data_in_ready), 64'd0);
      check("rst_wr_en", 64'(x_mem_wr_en), 64'd0);
      check("rst_wr_addr", 64'(x_mem_wr_addr), 64'd0);
      check("rst_wr_data_low", x_mem_wr_data[63:0], 64'd0);
      check("rst_done", 64'(load_x_done), 64'd0);
      check("rst_error", 64'(load_x_error), 64'd0);
      check("rst_beat_cnt", 64'(x_beat_cnt), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      run_load(32'd512, 64'h1000, 0, 0, -1, 1'b0);
      apply_reset();
      run_load(32'd513, 64'h2000, 0, 0, -1, 1'b0);
      run_load(32'd0, 64'h3000, 0, 0, -1, 1'b0);
      @(negedge clk);
      check("error_held", 64'(load_x_error), 64'd1);
      run_load(32'($urandom_range(3000, 1)), {32'h0, $urandom} & 64'hFFFF_FFC0, 5, 40, -1, 1'b0);
      check("error_cleared", 64'(load_x_error), 64'd0);
      run_load(32'd512, 64'h4000, 2, 20, -1, 1'b1);
      run_load(32'd512, 64'h5000, 0, 0, 10, 1'b0);
      run_load(32'd512, 64'h6000, 0, 0, -1, 1'b0);
      for (int t = 0; t < 3; t++)
         run_load(32'($urandom_range(4096, 1)), {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFC0,
                  $urandom_range(6, 0), $urandom_range(50, 0), -1, 1'b0);

      repeat (4) @(posedge clk);
      check("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
      check("write_queue_empty", 64'(exp_wr.size()), 64'd0);
      check("done_queue_empty", 64'(exp_done.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
